// File: rtl/ultrasonic_trig_ctrl.sv
// Ultrasonic ranging initiator: issues the sensor trigger pulse, watches the
// echo line until the measurement window closes, enforces the re-trigger
// holdoff and reports completion / timeout status.
module ultrasonic_trig_ctrl #(
  parameter int TRIG_CYCLES    = 1250,
  parameter int RISE_TIMEOUT   = 62500,
  parameter int ECHO_MAX       = 4750000,
  parameter int HOLDOFF_CYCLES = 7500000,
  parameter int CNT_W          = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       auto_en,
  input  logic       echo,
  output logic       trig,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [1:0] err_code
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_WAIT_FALL = 3'd3,
    S_HOLDOFF   = 3'd4
  } state_t;

  // Last counter value of each phase; the holdoff always lasts at least one cycle.
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(RISE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ECHO_LAST = CNT_W'(ECHO_MAX - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLDOFF_CYCLES > 1) ? HOLDOFF_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] phase_cnt_reg, hold_cnt_reg;
  logic             e1_reg, e2_reg;
  logic             rise, fall;
  logic             launch, phase_clr, hold_clr;
  logic             fin, fin_to;
  logic [1:0]       fin_err;
  logic             trig_reg, busy_reg, done_reg, timeout_reg;
  logic [1:0]       err_reg;
  logic             trig_next, busy_next, done_next, timeout_next;
  logic [1:0]       err_next;

  // Two-flop synchronizer for the asynchronous echo pin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e1_reg <= 1'b0;
      e2_reg <= 1'b0;
    end else begin
      e1_reg <= echo;
      e2_reg <= e1_reg;
    end
  end

  assign rise = e1_reg & ~e2_reg;
  assign fall = ~e1_reg & e2_reg;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; echo edges take priority over same-cycle expiry.
  always_comb begin
    state_next = state_reg;
    launch     = 1'b0;
    phase_clr  = 1'b0;
    hold_clr   = 1'b0;
    fin        = 1'b0;
    fin_to     = 1'b0;
    fin_err    = 2'b00;
    case (state_reg)
      S_IDLE: launch = start | auto_en;
      S_TRIG: begin
        if (phase_cnt_reg == TRIG_LAST) begin
          state_next = S_WAIT_RISE;
          phase_clr  = 1'b1;
        end
      end
      S_WAIT_RISE: begin
        if (rise) begin
          state_next = S_WAIT_FALL;
          phase_clr  = 1'b1;
        end else if (phase_cnt_reg >= RISE_LAST) begin
          state_next = S_HOLDOFF;
          fin        = 1'b1;
          fin_to     = 1'b1;
          fin_err    = 2'b01;
        end
      end
      S_WAIT_FALL: begin
        if (fall) begin
          state_next = S_HOLDOFF;
          fin        = 1'b1;
        end else if (phase_cnt_reg >= ECHO_LAST) begin
          state_next = S_HOLDOFF;
          fin        = 1'b1;
          fin_to     = 1'b1;
          fin_err    = 2'b10;
        end
      end
      S_HOLDOFF: begin
        // In free-running mode relaunch straight from holdoff expiry so that
        // trigger rises are spaced exactly by the holdoff interval.
        if (hold_cnt_reg >= HOLD_LAST) begin
          if (auto_en) launch = 1'b1;
          else         state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (launch) begin
      phase_clr = 1'b1;
      hold_clr  = 1'b1;
      if (e1_reg) begin
        // Echo already high: the sensor is not ready, abort without a pulse.
        state_next = S_HOLDOFF;
        fin        = 1'b1;
        fin_to     = 1'b1;
        fin_err    = 2'b11;
      end else begin
        state_next = S_TRIG;
      end
    end
  end

  // Output decode from the upcoming state and the completion decision.
  always_comb begin
    trig_next    = (state_next == S_TRIG);
    busy_next    = (state_next != S_IDLE);
    done_next    = fin;
    timeout_next = fin_to;
    err_next     = fin_err;
  end

  // Phase and holdoff counters, both saturating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_cnt_reg <= '0;
      hold_cnt_reg  <= '0;
    end else begin
      if (phase_clr)                     phase_cnt_reg <= '0;
      else if (phase_cnt_reg != CNT_MAX) phase_cnt_reg <= phase_cnt_reg + CNT_W'(1);
      if (hold_clr)                      hold_cnt_reg  <= '0;
      else if (hold_cnt_reg != CNT_MAX)  hold_cnt_reg  <= hold_cnt_reg + CNT_W'(1);
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trig_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      err_reg     <= 2'b00;
    end else begin
      trig_reg    <= trig_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      timeout_reg <= timeout_next;
      err_reg     <= err_next;
    end
  end

  assign trig     = trig_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign timeout  = timeout_reg;
  assign err_code = err_reg;

endmodule

// File: doc/ultrasonic_trig_ctrl.md
Name: ultrasonic_trig_ctrl

Overview:
Initiator side of the ultrasonic ranging interface: issues the sensor trigger pulse and supervises the echo line until the measurement window closes. It works alongside the echo-width counter that consumes the same echo line. It also enforces the sensor's minimum re-trigger interval, supports single-shot and free-running modes, and reports completion and timeout status. Runs on the 125 MHz system clock (8 ns period).

Parameters:
TRIG_CYCLES, 1250, trig high time in clk cycles (10 us)
RISE_TIMEOUT, 62500, max cycles from trig fall to echo rise (500 us)
ECHO_MAX, 4750000, max echo high time in cycles (38 ms)
HOLDOFF_CYCLES, 7500000, min cycles from trig rise to next trig rise (60 ms)
CNT_W, 23, width of shared phase counter; must hold the largest of the above

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  single-shot request; sampled only in IDLE
auto_en  in  1  free-running mode; when 1, a new cycle launches automatically
echo  in  1  raw sensor echo, asynchronous to clk
trig  out  1  sensor trigger, registered
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a cycle ends (normal or timeout)
timeout  out  1  valid with done: 1 = cycle aborted by timeout
err_code  out  2  valid with done: 00 ok, 01 no echo rise, 10 echo too long, 11 echo already high at trigger

Behaviour:
- Reset (reset=0, async): state=IDLE, counter=0, trig=0, busy=0, done=0, timeout=0, err_code=00, sync flops=0.
- echo passes through a 2-flop synchronizer (e1, e2). Rise = e1 & ~e2, fall = ~e1 & e2. Detection latency is 2 clk after a pin edge.
- All outputs are registered. done, timeout and err_code update together.
- IDLE:
  - If start|auto_en, go to TRIG, set counter=0 and trig=1 on the next edge.
  - If e1=1 at that moment, skip TRIG and go to HOLDOFF with done=1, timeout=1, err=11; trig stays 0.
- TRIG:
  - trig held high exactly TRIG_CYCLES clk cycles.
  - When counter=TRIG_CYCLES-1: trig<=0, go to WAIT_RISE, phase counter reset.
  - The holdoff counter keeps counting from trig rise.
- WAIT_RISE:
  - On rise, go to WAIT_FALL.
  - If counter reaches RISE_TIMEOUT-1 without rise: done=1, timeout=1, err=01, go to HOLDOFF.
- WAIT_FALL:
  - On fall: done=1, timeout=0, err=00, go to HOLDOFF.
  - If echo high for ECHO_MAX cycles: done=1, timeout=1, err=10, go to HOLDOFF.
- HOLDOFF:
  - Stay until HOLDOFF_CYCLES have elapsed since trig rise (minimum 1 cycle), then go to IDLE.
  - Echo activity here is ignored.
- Counters: one phase counter plus one holdoff counter (CNT_W bits each), both saturating. They never wrap.
- done is high for exactly 1 cycle per launched cycle and never in IDLE.
- start/auto_en asserted outside IDLE are ignored; no request is queued. A start pulse of 1 cycle in IDLE is enough.
- A rise and fall in the same detection cycle cannot occur because of the synchronizer. A rise on the same cycle as RISE_TIMEOUT expiry counts as rise (echo wins).
- A fall on the same cycle as ECHO_MAX expiry counts as ok (fall wins).
- Reset mid-cycle drops trig to 0 immediately (async) and returns to IDLE. The next launch needs a fresh start/auto_en.

Test Plan:
Sim parameters: TRIG_CYCLES=10, RISE_TIMEOUT=50, ECHO_MAX=200, HOLDOFF_CYCLES=400.
- Normal: 1-cycle start; echo high 20 cycles after trig fall, low 100 cycles later -> trig high exactly 10 cycles; done pulse 2-3 cycles after echo fall with err=00, timeout=0; busy drops 400 cycles after trig rise.
- No echo: start, echo held 0 -> done with timeout=1, err=01 exactly 50 cycles after trig fall; trig never re-asserts before holdoff ends.
- Long echo: echo rises then stays high 300 cycles -> done with err=10 200 cycles after detected rise; the late echo fall causes no second done.
- Auto mode: auto_en=1, echo answered normally -> successive trig rising edges exactly 400 cycles apart for 5 cycles; 5 done pulses.
- Stuck echo: echo=1 before start -> no trig pulse; done with err=11 on the cycle after start; next trig no earlier than the holdoff.
- Async reset: reset=0 at trig cycle 5 -> trig=0 and busy=0 without waiting for a clk edge; after release, no activity until start.
